load_store_unit: RTL and testbench

Multi-cycle data-memory access stage sitting directly downstream of the datapath's data_memory_addr / write_data outputs and upstream of its read_data input.
- Converts the core's single-cycle load/store request into a req/ack bus transaction.
- Generates word-aligned addresses and byte-lane strobes for word and byte (LDRB/STRB) accesses.
- Stalls the core until the access completes, faults, or times out.

---
 rtl/load_store_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle data-memory access stage. It turns the core's single-cycle
// load/store request into a req/ack bus transaction. It builds word-aligned
// bus addresses and byte-lane strobes, and it stalls the core until the access
// completes, faults on a misaligned word access, or times out.
//
// Optional feature (compile-time macro): LSU_HALFWORD_EN
//   When defined, a half_en input is added and halfword accesses are supported.
//   Access size priority is byte_en > half_en > word.
//   When undefined, only byte and word accesses exist and half_en is absent.
//
// Parameters:
//   TIMEOUT    number of REQ-state cycles without bus_ack before the access is
//              aborted (1..65535)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   mem_read    load request from control
//   mem_write   store request from control (wins over mem_read)
//   byte_en     1 = byte access
//   half_en     1 = halfword access (only with LSU_HALFWORD_EN)
//   addr        byte address from the datapath
//   write_data  store data from the datapath
//   read_data   formatted load result (holds until next load/fault)
//   stall       combinational: hold PC / register writes this cycle
//   fault       one-cycle pulse on misaligned access or timeout
//   bus_req     registered bus request
//   bus_we      registered write enable
//   bus_addr    registered word-aligned address
//   bus_wdata   registered store data, replicated across lanes for sub-word
//   bus_strb    registered byte-lane strobes
//   bus_ack     single-cycle bus completion
//   bus_rdata   bus read data, valid with bus_ack
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_en,
`ifdef LSU_HALFWORD_EN
    input  logic        half_en,
`endif
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Request decode (combinational, from the core's stable inputs)
    logic        req;
    logic        is_half;
    logic        misaligned;
    acc_size_t   size_d;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;

    // Load result formatting (from registered access shape)
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rdata_fmt_d;

    // State
    state_t      state_q;
    acc_size_t   size_q;
    logic [1:0]  lane_q;
    logic [15:0] cnt_q;

    // Registered outputs
    logic [31:0] read_data_q;
    logic        fault_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_strb_q;

    assign req = mem_read | mem_write;

    always_comb begin
        is_half = 1'b0;
`ifdef LSU_HALFWORD_EN
        is_half = ~byte_en & half_en;
`endif
    end

    // Access shape: strobes, lane-replicated store data and alignment check.
    // Sub-word stores replicate the data on every lane so the strobes alone
    // select what the memory actually writes.
    always_comb begin
        size_d     = SZ_WORD;
        misaligned = |addr[1:0];
        strb_d     = 4'b1111;
        wdata_d    = write_data;
        if (byte_en) begin
            size_d     = SZ_BYTE;
            misaligned = 1'b0;
            strb_d     = 4'b0001 << addr[1:0];
            wdata_d    = {4{write_data[7:0]}};
        end else if (is_half) begin
            size_d     = SZ_HALF;
            misaligned = addr[0];
            strb_d     = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d    = {2{write_data[15:0]}};
        end
    end

    // Lane selection uses the lane captured at request time, so the result
    // does not depend on the core keeping addr stable through the ack cycle.
    always_comb begin
        rbyte = bus_rdata[7:0];
        case (lane_q)
            2'd0:    rbyte = bus_rdata[7:0];
            2'd1:    rbyte = bus_rdata[15:8];
            2'd2:    rbyte = bus_rdata[23:16];
            default: rbyte = bus_rdata[31:24];
        endcase
        rhalf = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_BYTE: rdata_fmt_d = {24'b0, rbyte};
            SZ_HALF: rdata_fmt_d = {16'b0, rhalf};
            default: rdata_fmt_d = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_WORD;
            lane_q      <= 2'd0;
            cnt_q       <= 16'd0;
            read_data_q <= 32'd0;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_strb_q  <= 4'b0000;
        end else begin
            // fault is a pulse: it is only ever set for the cycle in DONE
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            read_data_q <= 32'd0;
                            fault_q     <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mem_write;
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_wdata_q <= wdata_d;
                            bus_strb_q  <= strb_d;
                            size_q      <= size_d;
                            lane_q      <= addr[1:0];
                            cnt_q       <= 16'd0;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so an ack on the timeout cycle wins
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        if (!bus_we_q) begin
                            read_data_q <= rdata_fmt_d;
                        end
                        state_q <= ST_DONE;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        bus_req_q   <= 1'b0;
                        read_data_q <= 32'd0;
                        fault_q     <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    cnt_q   <= 16'd0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // DONE is the single cycle the core is released to commit
    assign stall     = req & (state_q != ST_DONE);
    assign read_data = read_data_q;
    assign fault     = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_strb  = bus_strb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. The stimulus process computes, for every
// cycle of each access, what the outputs must be from the access rules (cycle
// counts, strobes, lane formatting). A single compare process checks the DUT
// against those expectations on every falling edge. Literal hand-computed
// values pin the model at key points.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        byte_en;
`ifdef LSU_HALFWORD_EN
    logic        half_en;
`endif
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .byte_en    (byte_en),
`ifdef LSU_HALFWORD_EN
        .half_en    (half_en),
`endif
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .fault      (fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_strb   (bus_strb),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle expectations
    logic        cmp_en;
    logic        exp_stall;
    logic        exp_req;
    logic        exp_fault;
    logic [31:0] exp_rd;
    logic        exp_bus_valid;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;

    // Model of the architecturally visible load result
    logic [31:0] model_rd;

    // Observation counters / captures (written only by the compare process)
    int          req_hi_cnt = 0;
    int          stall_hi_cnt = 0;
    int          fault_hi_cnt = 0;
    logic [31:0] cap_addr = 32'd0;
    logic [31:0] cap_wdata = 32'd0;
    logic [3:0]  cap_strb = 4'd0;
    logic        cap_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        byte_en       = 1'b0;
        bus_ack       = 1'b0;
        exp_stall     = 1'b0;
        exp_req       = 1'b0;
        exp_fault     = 1'b0;
        exp_rd        = model_rd;
        exp_bus_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        repeat (n) next_cycle();
    endtask

    // One core access. ack_cycle = REQ cycle (1-based) in which bus_ack is
    // driven; 0 means the bus never answers.
    task automatic access(input logic rd, input logic wr, input logic be,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_cycle, input logic [31:0] rdat);
        logic [1:0]  lane;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] fmt;
        logic [3:0]  e_strb;
        logic        mis;
        logic        timed_out;
        int          n;

        lane   = a[1:0];
        mis    = !be && (lane != 2'd0);
        e_addr = a & 32'hFFFF_FFFC;
        if (be) begin
            e_strb  = 4'(1 << lane);
            e_wdata = {24'b0, wd[7:0]} * 32'h0101_0101;
            fmt     = (rdat >> (8 * lane)) & 32'h0000_00FF;
        end else begin
            e_strb  = 4'hF;
            e_wdata = wd;
            fmt     = rdat;
        end

        // Cycle in IDLE: request presented, core stalled
        mem_read      = rd;
        mem_write     = wr;
        byte_en       = be;
        addr          = a;
        write_data    = wd;
        bus_ack       = 1'b0;
        exp_stall     = 1'b1;
        exp_req       = 1'b0;
        exp_fault     = 1'b0;
        exp_rd        = model_rd;
        exp_bus_valid = 1'b0;
        exp_we        = wr;
        exp_addr      = e_addr;
        exp_wdata     = e_wdata;
        exp_strb      = e_strb;
        next_cycle();

        timed_out = 1'b0;
        if (mis) begin
            model_rd  = 32'd0;
            exp_stall = 1'b0;
            exp_fault = 1'b1;
            exp_rd    = model_rd;
            next_cycle();
        end else begin
            timed_out = (ack_cycle < 1) || (ack_cycle > TO + 1);
            n = timed_out ? TO + 1 : ack_cycle;
            for (int c = 1; c <= n; c++) begin
                exp_stall     = 1'b1;
                exp_req       = 1'b1;
                exp_bus_valid = 1'b1;
                bus_ack       = (!timed_out && c == n);
                bus_rdata     = bus_ack ? rdat : $urandom();
                next_cycle();
            end
            bus_ack = 1'b0;
            if (timed_out) model_rd = 32'd0;
            else if (!wr)  model_rd = fmt;
            exp_stall     = 1'b0;
            exp_req       = 1'b0;
            exp_bus_valid = 1'b0;
            exp_fault     = timed_out;
            exp_rd        = model_rd;
            next_cycle();
        end
        set_idle();
        $display("txn rd=%0d wr=%0d byte=%0d addr=%h wdata=%h ack_cycle=%0d -> model read_data=%h fault=%0d",
                 rd, wr, be, a, wd, ack_cycle, model_rd, (mis || timed_out));
    endtask

    // Single compare process
    always @(negedge clk) begin
        if (bus_req) begin
            req_hi_cnt++;
            cap_addr  = bus_addr;
            cap_wdata = bus_wdata;
            cap_strb  = bus_strb;
            cap_we    = bus_we;
        end
        if (stall) stall_hi_cnt++;
        if (fault) fault_hi_cnt++;
        if (cmp_en) begin
            chk("stall",     32'(stall),   32'(exp_stall));
            chk("bus_req",   32'(bus_req), 32'(exp_req));
            chk("fault",     32'(fault),   32'(exp_fault));
            chk("read_data", read_data,    exp_rd);
            if (exp_bus_valid) begin
                chk("bus_we",    32'(bus_we),   32'(exp_we));
                chk("bus_addr",  bus_addr,      exp_addr);
                chk("bus_wdata", bus_wdata,     exp_wdata);
                chk("bus_strb",  32'(bus_strb), 32'(exp_strb));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s0;
    int r0;
    int f0;

    initial begin
        reset      = 1'b0;
        addr       = 32'd0;
        write_data = 32'd0;
        bus_rdata  = 32'd0;
`ifdef LSU_HALFWORD_EN
        half_en    = 1'b0;
`endif
        cmp_en     = 1'b0;
        model_rd   = 32'd0;
        exp_we     = 1'b0;
        exp_addr   = 32'd0;
        exp_wdata  = 32'd0;
        exp_strb   = 4'd0;
        set_idle();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_bus_req",   32'(bus_req),   32'd0);
        chk("rst_bus_we",    32'(bus_we),    32'd0);
        chk("rst_fault",     32'(fault),     32'd0);
        chk("rst_bus_addr",  bus_addr,       32'd0);
        chk("rst_bus_wdata", bus_wdata,      32'd0);
        chk("rst_bus_strb",  32'(bus_strb),  32'd0);
        chk("rst_read_data", read_data,      32'd0);
        reset  = 1'b1;
        cmp_en = 1'b1;
        idle_cycles(2);

        // bus_ack outside REQ is ignored
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        next_cycle();
        idle_cycles(1);

        // Test 1: word load, ack in first REQ cycle
        s0 = stall_hi_cnt;
        f0 = fault_hi_cnt;
        access(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'd0, 1, 32'hDEAD_BEEF);
        chk("t1_stall_cycles", 32'(stall_hi_cnt - s0), 32'd2);
        chk("t1_bus_addr",     cap_addr,               32'h0000_0104);
        chk("t1_bus_strb",     32'(cap_strb),          32'hF);
        chk("t1_read_data",    read_data,              32'hDEAD_BEEF);
        chk("t1_model_rd",     model_rd,               32'hDEAD_BEEF);
        chk("t1_faults",       32'(fault_hi_cnt - f0), 32'd0);

        // Test 2: byte store then byte load back-to-back
        access(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_56A5, 2, 32'd0);
        chk("t2_bus_addr",  cap_addr,      32'h0000_0200);
        chk("t2_bus_strb",  32'(cap_strb), 32'h8);
        chk("t2_bus_wdata", cap_wdata,     32'hA5A5_A5A5);
        chk("t2_bus_we",    32'(cap_we),   32'd1);
        chk("t2_store_rd",  read_data,     32'hDEAD_BEEF);
        access(1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'd0, 1, 32'hA500_0000);
        chk("t2_read_data", read_data,     32'h0000_00A5);
        chk("t2_model_rd",  model_rd,      32'h0000_00A5);
        access(1'b1, 1'b0, 1'b1, 32'h0000_1001, 32'd0, 3, 32'h1122_3344);
        chk("t2_lane1_rd",   read_data,     32'h0000_0033);
        chk("t2_lane1_strb", 32'(cap_strb), 32'h2);
        access(1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'd0, 1, 32'h1122_3344);
        chk("t2_lane0_rd",   read_data,     32'h0000_0044);
        access(1'b1, 1'b0, 1'b1, 32'h0000_1002, 32'd0, 2, 32'h1122_3344);
        chk("t2_lane2_rd",   read_data,     32'h0000_0022);

        // Test 3: misaligned word load
        r0 = req_hi_cnt;
        f0 = fault_hi_cnt;
        access(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'd0, 1, 32'h1234_5678);
        chk("t3_bus_req_cycles", 32'(req_hi_cnt - r0),   32'd0);
        chk("t3_fault_cycles",   32'(fault_hi_cnt - f0), 32'd1);
        chk("t3_read_data",      read_data,              32'd0);

        // Word store
        access(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 3, 32'd0);
        chk("ws_bus_wdata", cap_wdata, 32'hCAFE_F00D);

        // Test 4: timeout, then ack on the last allowed cycle
        access(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'd0, 1, 32'h0BAD_CAFE);
        r0 = req_hi_cnt;
        f0 = fault_hi_cnt;
        access(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'd0, 0, 32'd0);
        chk("t4_req_cycles",   32'(req_hi_cnt - r0),   32'd5);
        chk("t4_fault_cycles", 32'(fault_hi_cnt - f0), 32'd1);
        chk("t4_read_data",    read_data,              32'd0);
        r0 = req_hi_cnt;
        f0 = fault_hi_cnt;
        access(1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'd0, 5, 32'h600D_F00D);
        chk("t4b_req_cycles",   32'(req_hi_cnt - r0),   32'd5);
        chk("t4b_fault_cycles", 32'(fault_hi_cnt - f0), 32'd0);
        chk("t4b_read_data",    read_data,              32'h600D_F00D);

        // Test 6: read and write together is a store
        access(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0005, 1, 32'hFFFF_FFFF);
        chk("t6_bus_we",    32'(cap_we), 32'd1);
        chk("t6_bus_wdata", cap_wdata,   32'h0000_0005);
        chk("t6_bus_addr",  cap_addr,    32'h0000_0010);
        chk("t6_read_data", read_data,   32'h600D_F00D);

        // Test 5: asynchronous reset while in REQ
        cmp_en     = 1'b0;
        mem_write  = 1'b1;
        byte_en    = 1'b0;
        addr       = 32'h0000_0500;
        write_data = 32'h0000_0077;
        bus_ack    = 1'b0;
        next_cycle();
        next_cycle();
        chk("t5_req_before_reset", 32'(bus_req), 32'd1);
        #2;
        reset     = 1'b0;
        mem_write = 1'b0;
        #1;
        chk("t5_bus_req",   32'(bus_req),  32'd0);
        chk("t5_bus_we",    32'(bus_we),   32'd0);
        chk("t5_fault",     32'(fault),    32'd0);
        chk("t5_stall",     32'(stall),    32'd0);
        chk("t5_bus_addr",  bus_addr,      32'd0);
        chk("t5_bus_wdata", bus_wdata,     32'd0);
        chk("t5_bus_strb",  32'(bus_strb), 32'd0);
        chk("t5_read_data", read_data,     32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        model_rd = 32'd0;
        set_idle();
        cmp_en = 1'b1;
        f0 = fault_hi_cnt;
        access(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h89AB_CDEF, 2, 32'd0);
        chk("t5_post_wdata",  cap_wdata,              32'h89AB_CDEF);
        chk("t5_post_faults", 32'(fault_hi_cnt - f0), 32'd0);
        chk("t5_post_rd",     read_data,              32'd0);

        idle_cycles(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
